// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle ADD/SUB/LDI/NOP sequencer for an external 8-bit ALU (instr valid/ready in; alu_rd_data/alu_rs_data/alu_select out, alu_out in; done/result/result_zero out; dbg_addr/dbg_data regfile peek; optional ovf output under `ALU_SEQ_OVF_EN)
module alu_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int REG_ADDR_W = 2,
  localparam int INSTR_W = 2 + 2*REG_ADDR_W + DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [INSTR_W-1:0]    instr,
  output logic [DATA_W-1:0]     alu_rd_data,
  output logic [DATA_W-1:0]     alu_rs_data,
  output logic                  alu_select,
  input  logic [DATA_W-1:0]     alu_out,
  output logic                  done,
  output logic [DATA_W-1:0]     result,
  output logic                  result_zero,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic                  ovf
`endif
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state, next;
  logic [1:0] op;
  logic [REG_ADDR_W-1:0] rd, rs;
  logic [DATA_W-1:0] imm, pend, wdata;
  logic [DATA_W-1:0] regs [2**REG_ADDR_W];
  logic wr;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb
    next = state == IDLE ? (instr_valid ? READ : IDLE) :
           state == READ ? (op[1] ? WRITE : EXEC) :
           state == EXEC ? WRITE : IDLE;
  always_comb begin
    instr_ready = state == IDLE;
    done = state == WRITE;
    alu_select = state == EXEC && op[0];
  end
  assign wr = state == WRITE && op != 2'b11;
  assign wdata = op[1] ? imm : pend;
  assign dbg_data = regs[dbg_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {op, rd, rs, imm} <= '0;
      alu_rd_data <= '0;
      alu_rs_data <= '0;
      pend <= '0;
      result <= '0;
      result_zero <= 1'b1;
      regs <= '{default: '0};
    end else begin
      if (state == IDLE && instr_valid) {op, rd, rs, imm} <= instr;
      if (state == READ) begin
        alu_rd_data <= regs[rd];
        alu_rs_data <= regs[rs];
      end
      if (state == EXEC) pend <= alu_out;
      if (wr) begin
        regs[rd] <= wdata;
        result <= wdata;
        result_zero <= wdata == '0;
      end
    end
`ifdef ALU_SEQ_OVF_EN
  logic a, b, w;
  assign a = alu_rd_data[DATA_W-1];
  assign b = alu_rs_data[DATA_W-1];
  assign w = pend[DATA_W-1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (state == WRITE) ovf <= op[1] ? 1'b0 : (op[0] ? a != b && w != a : a == b && w != a);
`endif
endmodule
